lcd_timing_gen: RTL and testbench

- Upstream neighbour of the character-cell pixel generator in the Tang Nano 9k LCD RGB design.
- Derives the LCD pixel clock (lcd_dclk) from the system clock and produces the horizontal and vertical timing counters and strobes.
- Drives pos_x/pos_y into the pixel generator and places the lcd_dclk rising edge after that generator's fixed pipeline latency, so the panel samples a valid pixel.

---
 rtl/lcd_timing_gen_if.sv | 18 +
 rtl/lcd_timing_gen.sv | 90 +++++++++
 tb/tb_lcd_timing_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// Timing bundle from lcd_timing_gen to the pixel generator and the LCD panel pins.
interface lcd_timing_gen_if;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       lcd_dclk;
    logic       lcd_de;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       frame_start;

    modport master (
        output pos_x, pos_y, lcd_dclk, lcd_de, lcd_hsync, lcd_vsync, frame_start
    );

    modport slave (
        input pos_x, pos_y, lcd_dclk, lcd_de, lcd_hsync, lcd_vsync, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD dclk / hsync / vsync / DE timing generator with pixel position outputs.
// Macro LCD_SYNC_OUT_EN drives real sync pulses; without it the panel runs in DE-only mode.
module lcd_timing_gen #(
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 2,
    parameter int H_PULSE    = 41,
    parameter int H_BP       = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 2,
    parameter int V_PULSE    = 10,
    parameter int V_BP       = 2,
    parameter int CLK_DIV    = 10,
    parameter int PIPE_DELAY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_timing_gen_if.master lcd
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_nxt;
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          tick;
    logic          h_wrap;
    logic          de_nxt;
    logic          hs_nxt;
    logic          vs_nxt;

    // Next counter values; outputs are decoded from these so they settle on the tick edge itself.
    always_comb begin
        tick   = (int'(ph) == CLK_DIV - 1);
        ph_nxt = tick ? '0 : ph + PW'(1);
        h_wrap = (int'(h_cnt) == H_TOTAL - 1);
        h_nxt  = h_wrap ? '0 : h_cnt + HW'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
        end
        de_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
`ifdef LCD_SYNC_OUT_EN
        hs_nxt = !((int'(h_nxt) >= H_ACTIVE + H_FP) &&
                   (int'(h_nxt) <  H_ACTIVE + H_FP + H_PULSE));
        vs_nxt = !((int'(v_nxt) >= V_ACTIVE + V_FP) &&
                   (int'(v_nxt) <  V_ACTIVE + V_FP + V_PULSE));
`else
        hs_nxt = 1'b1;
        vs_nxt = 1'b1;
`endif
    end

    // Counters start one step before (0,0) so the first tick after reset opens a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph              <= '0;
            h_cnt           <= HW'(H_TOTAL - 1);
            v_cnt           <= VW'(V_TOTAL - 1);
            lcd.lcd_dclk    <= 1'b0;
            lcd.lcd_de      <= 1'b0;
            lcd.lcd_hsync   <= 1'b1;
            lcd.lcd_vsync   <= 1'b1;
            lcd.pos_x       <= '0;
            lcd.pos_y       <= '0;
            lcd.frame_start <= 1'b0;
        end else begin
            ph              <= ph_nxt;
            lcd.lcd_dclk    <= (int'(ph_nxt) > PIPE_DELAY);
            lcd.frame_start <= 1'b0;
            if (tick) begin
                h_cnt           <= h_nxt;
                v_cnt           <= v_nxt;
                lcd.lcd_de      <= de_nxt;
                lcd.lcd_hsync   <= hs_nxt;
                lcd.lcd_vsync   <= vs_nxt;
                lcd.pos_x       <= (int'(h_nxt) < H_ACTIVE) ? 10'(h_nxt) : 10'd0;
                lcd.pos_y       <= (int'(v_nxt) < V_ACTIVE) ? 9'(v_nxt) : 9'd0;
                lcd.frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a full-size instance for line timing and a small one for whole frames.
module tb_lcd_timing_gen;

    localparam int BHA = 480, BHF = 2, BHP = 41, BHB = 2;
    localparam int BVA = 272, BVF = 2, BVP = 10, BVB = 2;
    localparam int BDIV = 10, BPD = 4;
    localparam int BHT = BHA + BHF + BHP + BHB;

    localparam int SHA = 64, SHF = 2, SHP = 4, SHB = 2;
    localparam int SVA = 32, SVF = 2, SVP = 3, SVB = 2;
    localparam int SDIV = 6, SPD = 4;
    localparam int SHT = SHA + SHF + SHP + SHB;
    localparam int SVT = SVA + SVF + SVP + SVB;

    // Flag order: dclk, de, hsync, vsync, frame_start
    localparam logic [23:0] RESET_VEC      = {10'd0, 9'd0, 5'b00110};
    localparam logic [23:0] FIRST_TICK_VEC = {10'd0, 9'd0, 5'b01111};

`ifdef LCD_SYNC_OUT_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_big_n = 1'b0;
    logic rst_small_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   c_big;
    int   c_small;

    lcd_timing_gen_if big_if ();
    lcd_timing_gen_if small_if ();

    lcd_timing_gen u_big (
        .clk   (clk),
        .rst_n (rst_big_n),
        .lcd   (big_if.master)
    );

    lcd_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_PULSE(SHP), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_PULSE(SVP), .V_BP(SVB),
        .CLK_DIV(SDIV), .PIPE_DELAY(SPD)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_small_n),
        .lcd   (small_if.master)
    );

    logic [23:0] big_obs;
    logic [23:0] small_obs;
    assign big_obs   = {big_if.pos_x, big_if.pos_y, big_if.lcd_dclk, big_if.lcd_de,
                        big_if.lcd_hsync, big_if.lcd_vsync, big_if.frame_start};
    assign small_obs = {small_if.pos_x, small_if.pos_y, small_if.lcd_dclk, small_if.lcd_de,
                        small_if.lcd_hsync, small_if.lcd_vsync, small_if.frame_start};

    always #5 clk = ~clk;

    // Clock edges seen since each instance left reset
    always @(posedge clk or negedge rst_big_n) begin
        if (!rst_big_n) c_big <= 0;
        else            c_big <= c_big + 1;
    end

    always @(posedge clk or negedge rst_small_n) begin
        if (!rst_small_n) c_small <= 0;
        else              c_small <= c_small + 1;
    end

    // Expected outputs after c clock edges from reset release, from tick count arithmetic
    function automatic logic [23:0] model(input int c, input int ha, input int hf, input int hp,
                                          input int hb, input int va, input int vf, input int vp,
                                          input int vb, input int div, input int pd);
        int   ht, vt, ph, ticks, k, h, v;
        logic dclk, de, hs, vs, fs;
        logic [9:0] px;
        logic [8:0] py;
        ht    = ha + hf + hp + hb;
        vt    = va + vf + vp + vb;
        ph    = c % div;
        ticks = c / div;
        dclk  = (ph > pd);
        if (ticks == 0) return {10'd0, 9'd0, dclk, 1'b0, 1'b1, 1'b1, 1'b0};
        k  = ticks - 1;
        h  = k % ht;
        v  = (k / ht) % vt;
        de = (h < ha) && (v < va);
        px = (h < ha) ? 10'(h) : 10'd0;
        py = (v < va) ? 9'(v) : 9'd0;
        hs = 1'b1;
        vs = 1'b1;
        if (SYNC_EN) begin
            hs = !((h >= ha + hf) && (h < ha + hf + hp));
            vs = !((v >= va + vf) && (v < va + vf + vp));
        end
        fs = (ph == 0) && (h == 0) && (v == 0);
        return {px, py, dclk, de, hs, vs, fs};
    endfunction

    function automatic logic [23:0] model_big(input int c);
        return model(c, BHA, BHF, BHP, BHB, BVA, BVF, BVP, BVB, BDIV, BPD);
    endfunction

    function automatic logic [23:0] model_small(input int c);
        return model(c, SHA, SHF, SHP, SHB, SVA, SVF, SVP, SVB, SDIV, SPD);
    endfunction

    task automatic test_reset();
        logic [23:0] exp_v;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        checks++;
        if (big_obs !== RESET_VEC) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", big_obs, RESET_VEC);
        end
        rst_big_n = 1'b1;
        for (int i = 0; i < 3 * BDIV; i++) begin
            @(negedge clk);
            exp_v = model_big(c_big);
            checks++;
            if (big_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL reset_release c=%0d: got %h expected %h", c_big, big_obs, exp_v);
            end
            if (c_big == BDIV) begin
                checks++;
                if (big_obs !== FIRST_TICK_VEC) begin
                    failures++;
                    $display("[TB] FAIL first_tick: got %h expected %h", big_obs, FIRST_TICK_VEC);
                end
            end
            if (c_big == BDIV + BPD + 1) begin
                checks++;
                if (big_if.lcd_dclk !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL dclk_rise: got %b expected 1", big_if.lcd_dclk);
                end
            end
        end
    endtask

    task automatic test_dclk_shape();
        logic [23:0] exp_v;
        logic        prev_dclk;
        logic [9:0]  prev_x;
        int          run, rises, waited;
        waited = 0;
        while ((c_big % BDIV) != 0 && waited < 2 * BDIV) begin
            @(negedge clk);
            waited++;
        end
        run       = 1;
        rises     = 0;
        prev_dclk = big_if.lcd_dclk;
        prev_x    = big_if.pos_x;
        for (int i = 1; i < 10 * BDIV; i++) begin
            @(negedge clk);
            exp_v = model_big(c_big);
            checks++;
            if (big_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL dclk_model c=%0d: got %h expected %h", c_big, big_obs, exp_v);
            end
            if (big_if.pos_x !== prev_x) begin
                checks++;
                if (big_if.lcd_dclk !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL pos_x_change_dclk: got dclk=%b expected 0", big_if.lcd_dclk);
                end
            end
            if (big_if.lcd_dclk === prev_dclk) begin
                run++;
            end else begin
                checks++;
                if (run != (prev_dclk ? BDIV - BPD - 1 : BPD + 1)) begin
                    failures++;
                    $display("[TB] FAIL dclk_run_len level=%b: got %0d expected %0d", prev_dclk, run,
                             prev_dclk ? BDIV - BPD - 1 : BPD + 1);
                end
                if (big_if.lcd_dclk === 1'b1) rises++;
                run = 1;
            end
            prev_dclk = big_if.lcd_dclk;
            prev_x    = big_if.pos_x;
        end
        checks++;
        if (rises != 10) begin
            failures++;
            $display("[TB] FAIL dclk_periods: got %0d expected 10", rises);
        end
    endtask

    task automatic test_line_walk();
        logic [23:0] exp_v;
        int de_ticks, hs_ticks, first_hs, t;
        @(negedge clk);
        #2 rst_big_n = 1'b0;
        #1;
        checks++;
        if (big_obs !== RESET_VEC) begin
            failures++;
            $display("[TB] FAIL line_reset_async: got %h expected %h", big_obs, RESET_VEC);
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rst_big_n = 1'b1;
        de_ticks = 0;
        hs_ticks = 0;
        first_hs = -1;
        for (int i = 0; i < (BHT + 2) * BDIV; i++) begin
            @(negedge clk);
            exp_v = model_big(c_big);
            checks++;
            if (big_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL line_model c=%0d: got %h expected %h", c_big, big_obs, exp_v);
            end
            if ((c_big % BDIV) == 0) begin
                t = c_big / BDIV;
                if (t >= 1 && t <= BHT) begin
                    if (big_if.lcd_de === 1'b1) de_ticks++;
                    if (big_if.lcd_hsync === 1'b0) begin
                        hs_ticks++;
                        if (first_hs < 0) first_hs = t - 1;
                    end
                end
                if (t == BHT + 1) begin
                    checks++;
                    if (big_if.pos_x !== 10'd0 || big_if.pos_y !== 9'd1) begin
                        failures++;
                        $display("[TB] FAIL next_line_pos: got (%0d,%0d) expected (0,1)",
                                 big_if.pos_x, big_if.pos_y);
                    end
                end
            end
        end
        checks++;
        if (de_ticks != BHA) begin
            failures++;
            $display("[TB] FAIL line_de_ticks: got %0d expected %0d", de_ticks, BHA);
        end
        checks++;
        if (hs_ticks != (SYNC_EN ? BHP : 0)) begin
            failures++;
            $display("[TB] FAIL line_hsync_ticks: got %0d expected %0d", hs_ticks, SYNC_EN ? BHP : 0);
        end
        checks++;
        if (first_hs != (SYNC_EN ? BHA + BHF : -1)) begin
            failures++;
            $display("[TB] FAIL line_hsync_start: got %0d expected %0d", first_hs,
                     SYNC_EN ? BHA + BHF : -1);
        end
        rst_big_n = 1'b0;
    endtask

    task automatic test_frame_walk();
        logic [23:0] exp_v;
        int fs_at[$];
        int vs_cycles, hs_cycles, max_py;
        @(negedge clk);
        rst_small_n = 1'b1;
        vs_cycles = 0;
        hs_cycles = 0;
        max_py    = 0;
        for (int i = 0; i < (SVT * SHT + 2) * SDIV; i++) begin
            @(negedge clk);
            exp_v = model_small(c_small);
            checks++;
            if (small_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL frame_model c=%0d: got %h expected %h", c_small, small_obs, exp_v);
            end
            if (small_if.lcd_vsync === 1'b0) vs_cycles++;
            if (small_if.lcd_hsync === 1'b0) hs_cycles++;
            if (small_if.frame_start === 1'b1) fs_at.push_back(c_small);
            if (int'(small_if.pos_y) > max_py) max_py = int'(small_if.pos_y);
        end
        checks++;
        if (vs_cycles != (SYNC_EN ? SVP * SHT * SDIV : 0)) begin
            failures++;
            $display("[TB] FAIL frame_vsync_len: got %0d expected %0d", vs_cycles,
                     SYNC_EN ? SVP * SHT * SDIV : 0);
        end
        checks++;
        if (hs_cycles != (SYNC_EN ? SHP * SVT * SDIV : 0)) begin
            failures++;
            $display("[TB] FAIL frame_hsync_len: got %0d expected %0d", hs_cycles,
                     SYNC_EN ? SHP * SVT * SDIV : 0);
        end
        checks++;
        if (fs_at.size() != 2) begin
            failures++;
            $display("[TB] FAIL frame_start_count: got %0d expected 2", fs_at.size());
        end else begin
            checks++;
            if (fs_at[1] - fs_at[0] != SVT * SHT * SDIV) begin
                failures++;
                $display("[TB] FAIL frame_period: got %0d expected %0d", fs_at[1] - fs_at[0],
                         SVT * SHT * SDIV);
            end
        end
        checks++;
        if (max_py != SVA - 1) begin
            failures++;
            $display("[TB] FAIL frame_max_pos_y: got %0d expected %0d", max_py, SVA - 1);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [23:0] exp_v;
        int tx, ty, target;
        @(negedge clk);
        rst_small_n = 1'b0;
        @(negedge clk);
        rst_small_n = 1'b1;
        tx     = $urandom_range(0, SHA - 1);
        ty     = $urandom_range(1, SVA - 1);
        target = (ty * SHT + tx + 1) * SDIV + $urandom_range(0, SDIV - 1);
        for (int i = 0; i < target; i++) begin
            @(negedge clk);
            exp_v = model_small(c_small);
            checks++;
            if (small_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL midreset_run c=%0d: got %h expected %h", c_small, small_obs, exp_v);
            end
        end
        checks++;
        if (small_if.pos_x !== 10'(tx) || small_if.pos_y !== 9'(ty) || small_if.lcd_de !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_pos: got (%0d,%0d,de=%b) expected (%0d,%0d,de=1)",
                     small_if.pos_x, small_if.pos_y, small_if.lcd_de, tx, ty);
        end
        #2 rst_small_n = 1'b0;
        #1;
        checks++;
        if (small_obs !== RESET_VEC) begin
            failures++;
            $display("[TB] FAIL midreset_async: got %h expected %h", small_obs, RESET_VEC);
        end
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            checks++;
            if (small_obs !== RESET_VEC) begin
                failures++;
                $display("[TB] FAIL midreset_hold: got %h expected %h", small_obs, RESET_VEC);
            end
        end
        rst_small_n = 1'b1;
        for (int i = 0; i < 3 * SDIV + 2; i++) begin
            @(negedge clk);
            exp_v = model_small(c_small);
            checks++;
            if (small_obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL midreset_restart c=%0d: got %h expected %h", c_small, small_obs, exp_v);
            end
            if (c_small == SDIV) begin
                checks++;
                if (small_obs !== FIRST_TICK_VEC) begin
                    failures++;
                    $display("[TB] FAIL midreset_first_tick: got %h expected %h", small_obs, FIRST_TICK_VEC);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] lcd_timing_gen bench start, sync outputs %s", SYNC_EN ? "enabled" : "tied high");
        test_reset();
        test_dclk_shape();
        test_line_walk();
        test_frame_walk();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
